// File: rtl/fsk_pkg.sv
// Shared FSK link constants: symbol timing, frame size and decision thresholds.
// The modulator and demodulator both take their defaults from here.
package fsk_pkg;

    localparam int SYM_LEN_DEF    = 16;
    localparam int FRAME_BITS_DEF = 9;
    localparam int THRESH_DEF     = 12;
    localparam int ERR_LO_DEF     = 10;
    localparam int ERR_HI_DEF     = 13;

    // True when v lies in the closed range [lo, hi].
    function automatic logic in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fsk_sym_detect.sv
// Per-symbol edge counter and bit decision. The decision outputs are valid
// combinationally on the last cycle of each symbol window (strobe_o high).
module fsk_sym_detect
    import fsk_pkg::*;
#(
    parameter int SYM_LEN = SYM_LEN_DEF,
    parameter int THRESH  = THRESH_DEF,
    parameter int ERR_LO  = ERR_LO_DEF,
    parameter int ERR_HI  = ERR_HI_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic fsk_i,
    output logic bit_o,
    output logic ambiguous_o,
    output logic strobe_o
);

    localparam int SC_W  = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int CNT_W = $clog2(SYM_LEN + 1);

    logic             fsk_d_q;
    logic [SC_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] total_s;
    logic             edge_s, last_s;

    // Window total includes the edge of the closing cycle, so nothing is lost at the wrap.
    always_comb begin
        edge_s  = fsk_i ^ fsk_d_q;
        last_s  = (sym_cnt_q == SC_W'(SYM_LEN - 1));
        total_s = edge_cnt_q + CNT_W'(edge_s);
        if (last_s) begin
            sym_cnt_d  = {SC_W{1'b0}};
            edge_cnt_d = {CNT_W{1'b0}};
        end else begin
            sym_cnt_d  = sym_cnt_q + SC_W'(1);
            edge_cnt_d = total_s;
        end
    end

    assign bit_o       = (total_s >= CNT_W'(THRESH));
    assign ambiguous_o = in_range(32'(total_s), ERR_LO, ERR_HI);
    assign strobe_o    = last_s;

    // Line delay, symbol counter and edge accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsk_d_q    <= 1'b0;
            sym_cnt_q  <= {SC_W{1'b0}};
            edge_cnt_q <= {CNT_W{1'b0}};
        end else begin
            fsk_d_q    <= fsk_i;
            sym_cnt_q  <= sym_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/fsk_demod.sv
// FSK demodulator top: assembles symbol decisions into frames and reports
// ambiguous symbols per decision (sym_err) and per frame (frame_err).
module fsk_demod
    import fsk_pkg::*;
#(
    parameter int SYM_LEN    = SYM_LEN_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int ERR_LO     = ERR_LO_DEF,
    parameter int ERR_HI     = ERR_HI_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fsk_in,
    output logic [FRAME_BITS-1:0] dataout,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  sym_err
);

    localparam int BI_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    logic                  bit_s, amb_s, strobe_s;
    logic [BI_W-1:0]       bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] asm_q, asm_d;
    logic [FRAME_BITS-1:0] dataout_q, dataout_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic                  frame_err_q, frame_err_d;
    logic                  valid_q, valid_d;
    logic                  sym_err_q, sym_err_d;

    fsk_sym_detect #(
        .SYM_LEN (SYM_LEN),
        .THRESH  (THRESH),
        .ERR_LO  (ERR_LO),
        .ERR_HI  (ERR_HI)
    ) u_sym_detect (
        .clk         (clk),
        .reset       (reset),
        .fsk_i       (fsk_in),
        .bit_o       (bit_s),
        .ambiguous_o (amb_s),
        .strobe_o    (strobe_s)
    );

    // Frame assembly; the last bit of a frame is folded into dataout on the same edge.
    always_comb begin
        asm_d       = asm_q;
        bit_idx_d   = bit_idx_q;
        ferr_acc_d  = ferr_acc_q;
        dataout_d   = dataout_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;
        sym_err_d   = 1'b0;
        if (strobe_s) begin
            sym_err_d        = amb_s;
            asm_d[bit_idx_q] = bit_s;
            if (bit_idx_q == BI_W'(FRAME_BITS - 1)) begin
                dataout_d   = asm_d;
                frame_err_d = ferr_acc_q | amb_s;
                valid_d     = 1'b1;
                ferr_acc_d  = 1'b0;
                bit_idx_d   = {BI_W{1'b0}};
            end else begin
                ferr_acc_d  = ferr_acc_q | amb_s;
                bit_idx_d   = bit_idx_q + BI_W'(1);
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Framing state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx_q   <= {BI_W{1'b0}};
            asm_q       <= {FRAME_BITS{1'b0}};
            ferr_acc_q  <= 1'b0;
            dataout_q   <= {FRAME_BITS{1'b0}};
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            sym_err_q   <= 1'b0;
        end else begin
            bit_idx_q   <= bit_idx_d;
            asm_q       <= asm_d;
            ferr_acc_q  <= ferr_acc_d;
            dataout_q   <= dataout_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            sym_err_q   <= sym_err_d;
        end
    end

    assign dataout   = dataout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign sym_err   = sym_err_q;

endmodule

// File: tb/tb_fsk_demod.sv
// Bench for fsk_demod: an ideal modulator pattern (1 = toggle every clock,
// 0 = toggle every other clock) feeds the DUT; a window-count model predicts outputs.
module tb_fsk_demod;

    localparam int SL   = 16;
    localparam int FB   = 9;
    localparam int FL   = SL * FB;
    localparam int MAXC = 4 * FL;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          fsk_in = 1'b0;
    logic [FB-1:0] dataout;
    logic          valid, frame_err, sym_err;

    int n_cmp = 0;
    int n_bad = 0;

    bit ap   [MAXC];
    int wcnt [MAXC/SL];

    typedef struct {
        logic [FB-1:0] data;
        int            delay;
        int            ovr_win;
        int            ovr_cnt;
        int            nframes;
        logic [FB-1:0] exp_data;
        logic          exp_ferr;
        int            exp_serr;
    } vec_t;

    always #5 clk = ~clk;

    fsk_demod dut (
        .clk       (clk),
        .reset     (reset),
        .fsk_in    (fsk_in),
        .dataout   (dataout),
        .valid     (valid),
        .frame_err (frame_err),
        .sym_err   (sym_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build the applied toggle stream and per-window toggle counts.
    task automatic build(input vec_t v, output int ncyc);
        bit base [MAXC];
        ncyc = v.nframes * FL;
        for (int n = 0; n < ncyc; n++) begin
            int w = n / SL;
            int p = n % SL;
            if (w == v.ovr_win) base[n] = (p < v.ovr_cnt);
            else if (v.data[w % FB]) base[n] = 1'b1;
            else base[n] = ((p % 2) == 0);
        end
        for (int n = 0; n < ncyc; n++)
            ap[n] = (n >= v.delay) ? base[n - v.delay] : 1'b0;
        for (int w = 0; w < ncyc / SL; w++) begin
            wcnt[w] = 0;
            for (int p = 0; p < SL; p++) wcnt[w] += int'(ap[w*SL + p]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        fsk_in = 1'b0;
        #1;
        check("rst_dataout", 32'(dataout), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_sym_err", 32'(sym_err), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Release reset and stream a scenario, checking every cycle against the model.
    task automatic run(input vec_t v, input int stop_at, input bit full);
        int            ncyc;
        bit            line;
        logic [FB-1:0] exp_do, asmb;
        logic          exp_fe, acc;
        int            first_valid, last_valid, serr_seen;
        build(v, ncyc);
        if (!full) ncyc = stop_at;
        line = 1'b0; exp_do = '0; asmb = '0; exp_fe = 1'b0; acc = 1'b0;
        first_valid = -1; last_valid = -1; serr_seen = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            logic e_valid, e_serr;
            if (n > 0) @(negedge clk);
            line   = line ^ ap[n];
            fsk_in = line;
            @(posedge clk);
            #1;
            e_valid = 1'b0;
            e_serr  = 1'b0;
            if ((n % SL) == SL - 1) begin
                int w = n / SL;
                int c = wcnt[w];
                e_serr = (c >= 10) && (c <= 13);
                asmb[w % FB] = (c >= 12);
                acc = acc | e_serr;
                if ((w % FB) == FB - 1) begin
                    e_valid = 1'b1;
                    exp_do  = asmb;
                    exp_fe  = acc;
                    acc     = 1'b0;
                end
            end
            check("valid", 32'(valid), 32'(e_valid));
            check("sym_err", 32'(sym_err), 32'(e_serr));
            check("dataout", 32'(dataout), 32'(exp_do));
            check("frame_err", 32'(frame_err), 32'(exp_fe));
            if (sym_err === 1'b1) serr_seen++;
            if (valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = n + 2;
                    check("first_frame_data", 32'(dataout), 32'(v.exp_data));
                    check("first_frame_err", 32'(frame_err), 32'(v.exp_ferr));
                end else begin
                    check("valid_spacing", 32'(n - last_valid), 32'(FL));
                end
                last_valid = n;
            end
        end
        if (full) begin
            check("first_valid_period", 32'(first_valid), 32'(FL + 1));
            check("sym_err_count", 32'(serr_seen), 32'(v.exp_serr));
        end
    endtask

    initial begin
        vec_t tbl [10];
        tbl[0] = '{9'h1A5, 0, -1,  0, 3, 9'h1A5, 1'b0, 0};
        tbl[1] = '{9'h1FF, 0, -1,  0, 2, 9'h1FF, 1'b0, 0};
        tbl[2] = '{9'h000, 0, -1,  0, 2, 9'h000, 1'b0, 0};
        tbl[3] = '{9'h1AD, 0,  3, 11, 2, 9'h1A5, 1'b1, 1};
        tbl[4] = '{9'h000, 0,  5, 12, 2, 9'h020, 1'b1, 1};
        tbl[5] = '{9'h000, 0,  7, 14, 2, 9'h080, 1'b0, 0};
        tbl[6] = '{9'h0F3, 2, -1,  0, 2, 9'h0F3, 1'b0, 0};
        for (int i = 7; i < 10; i++) begin
            int unsigned r  = $urandom;
            int          dl = int'($urandom_range(0, 2));
            logic [FB-1:0] d = r[FB-1:0];
            tbl[i] = '{d, dl, -1, 0, 2, d, 1'b0, 0};
        end

        for (int i = 0; i < 10; i++) begin
            do_reset();
            run(tbl[i], 0, 1'b1);
        end

        // Reset 70 clocks into the second frame, then a full clean run.
        do_reset();
        run(tbl[0], FL + 70, 1'b0);
        do_reset();
        run(tbl[0], 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
